// File: rtl/issue_sched.sv
// rtl/issue_sched.sv - age-ordered collapsing issue queue with operand wakeup
//
// Holds renamed ops until all four operand-ready flags (instr[7:4]) are set,
// then issues the oldest fully-ready op downstream.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        synchronous discard of all entries
//   in_valid/in_instr/in_ready      dispatch side (valid/ready)
//   wake_valid/wake_tag             NUM_WAKE result broadcast buses
//   out_valid/out_instr/out_ready   functional-unit side (valid/ready)
//   count        number of occupied entries

`ifndef RENAMED_OP_SZ
`define RENAMED_OP_SZ 32
`endif

module issue_sched #(
    parameter int INST_WIDTH = `RENAMED_OP_SZ,
    parameter int TAG_W      = 6,
    parameter int DEPTH      = 4,
    parameter int NUM_WAKE   = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [INST_WIDTH-1:0]        in_instr,
    output logic                         in_ready,
    input  logic [NUM_WAKE-1:0]          wake_valid,
    input  logic [NUM_WAKE*TAG_W-1:0]    wake_tag,
    output logic                         out_valid,
    output logic [INST_WIDTH-1:0]        out_instr,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0][INST_WIDTH-1:0] entry_q, entry_d;
    logic [CNT_W-1:0]                 count_q, count_d;

    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic             enq, iss;
    logic [CNT_W-1:0] wr_slot;

    // Returns op with any operand flag set whose source tag matches a live broadcast.
    function automatic logic [INST_WIDTH-1:0] wake_op(input logic [INST_WIDTH-1:0] op);
        logic [INST_WIDTH-1:0] r;
        r = op;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < NUM_WAKE; j++) begin
                if (wake_valid[j] && (wake_tag[j*TAG_W +: TAG_W] == op[8 + k*TAG_W +: TAG_W])) begin
                    r[4 + k] = 1'b1;
                end
            end
        end
        return r;
    endfunction

    assign count    = count_q;
    assign in_ready = (count_q < CNT_W'(DEPTH));

    // Oldest-ready select: scan from youngest to oldest so the lowest index wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if ((CNT_W'(i) < count_q) && (&entry_q[i][7:4])) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
        out_valid = sel_found;
        out_instr = sel_found ? entry_q[sel_idx] : '0;
    end

    always_comb begin
        iss     = sel_found & out_ready;
        enq     = in_valid & in_ready;
        // New op lands just above the surviving entries after any collapse.
        wr_slot = count_q - CNT_W'(iss);
        for (int i = 0; i < DEPTH; i++) begin
            int src;
            src = i;
            if (iss && (IDX_W'(i) >= sel_idx) && (i < DEPTH - 1)) begin
                src = i + 1;
            end
            entry_d[i] = wake_op(entry_q[src]);
            if (enq && (CNT_W'(i) == wr_slot)) begin
                entry_d[i] = wake_op(in_instr);
            end
        end
        count_d = count_q + CNT_W'(enq) - CNT_W'(iss);
        if (flush) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '0;
            count_q <= '0;
        end else begin
            entry_q <= entry_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_issue_sched.sv
// tb/tb_issue_sched.sv - self-checking bench for issue_sched

module tb_issue_sched;

    localparam int IW = 32;
    localparam int TW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [IW-1:0] in_instr = '0;
    logic          in_ready;
    logic [1:0]    wake_valid = '0;
    logic [2*TW-1:0] wake_tag = '0;
    logic          out_valid;
    logic [IW-1:0] out_instr;
    logic          out_ready = 1'b0;
    logic [2:0]    count;

    int n_checks = 0;
    int n_pass = 0;
    logic [IW-1:0] exp_q[$];
    logic [IW-1:0] exp_v;

    issue_sched #(.INST_WIDTH(IW), .TAG_W(TW), .DEPTH(4), .NUM_WAKE(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .wake_valid(wake_valid), .wake_tag(wake_tag),
        .out_valid(out_valid), .out_instr(out_instr), .out_ready(out_ready),
        .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] mk(input logic [3:0] flags, input logic [5:0] t0,
                                         input logic [5:0] t1, input logic [5:0] t2,
                                         input logic [5:0] t3, input logic [3:0] id);
        return {t3, t2, t1, t0, flags, id};
    endfunction

    function automatic logic [IW-1:0] ready_of(input logic [IW-1:0] op);
        return op | 32'h0000_00F0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [IW-1:0] op);
        in_valid = 1'b1;
        in_instr = op;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_checks++; if (count !== 3'd0) $display("FAIL reset_count got %0d exp 0", count); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (out_instr !== '0) $display("FAIL reset_out_instr got %h exp 0", out_instr); else n_pass++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        logic [IW-1:0] a;
        a = mk(4'b1111, 6'd1, 6'd2, 6'd3, 6'd4, 4'hA);
        exp_q.push_back(a);
        enq(a);
        n_checks++; if (out_valid !== 1'b1) $display("FAIL single_valid got %b exp 1", out_valid); else n_pass++;
        exp_v = exp_q.pop_front();
        n_checks++; if (out_instr !== exp_v) $display("FAIL single_instr got %h exp %h", out_instr, exp_v); else n_pass++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++; if (count !== 3'd0) $display("FAIL single_count got %0d exp 0", count); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL single_drain got %b exp 0", out_valid); else n_pass++;
    endtask

    task automatic test_young_first();
        logic [IW-1:0] a, b;
        a = mk(4'b1110, 6'd5, 6'd7, 6'd7, 6'd7, 4'h1);
        b = mk(4'b1111, 6'd2, 6'd2, 6'd2, 6'd2, 4'h2);
        exp_q.push_back(b);
        exp_q.push_back(ready_of(a));
        enq(a);
        enq(b);
        exp_v = exp_q.pop_front();
        n_checks++; if (out_valid !== 1'b1 || out_instr !== exp_v)
            $display("FAIL young_first got %b/%h exp 1/%h", out_valid, out_instr, exp_v); else n_pass++;
        out_ready = 1'b1;
        step();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL young_blocked got %b exp 0", out_valid); else n_pass++;
        wake_valid = 2'b10;
        wake_tag = {6'd5, 6'd0};
        step();
        wake_valid = 2'b00;
        exp_v = exp_q.pop_front();
        n_checks++; if (out_valid !== 1'b1 || out_instr !== exp_v)
            $display("FAIL young_woken got %b/%h exp 1/%h", out_valid, out_instr, exp_v); else n_pass++;
        step();
        out_ready = 1'b0;
        n_checks++; if (count !== 3'd0) $display("FAIL young_count got %0d exp 0", count); else n_pass++;
    endtask

    task automatic test_full();
        logic [IW-1:0] op;
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            op = mk(4'b0000, 6'(10 + 4*n), 6'(11 + 4*n), 6'(12 + 4*n), 6'(13 + 4*n), 4'(n));
            exp_q.push_back(ready_of(op));
            enq(op);
        end
        n_checks++; if (count !== 3'd4) $display("FAIL full_count got %0d exp 4", count); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL full_in_ready got %b exp 0", in_ready); else n_pass++;
        enq(mk(4'b1111, 6'd0, 6'd0, 6'd0, 6'd0, 4'hF));
        n_checks++; if (count !== 3'd4) $display("FAIL full_reject got %0d exp 4", count); else n_pass++;
        out_ready = 1'b0;
        for (int t = 10; t < 26; t += 2) begin
            wake_valid = 2'b11;
            wake_tag = {6'(t + 1), 6'(t)};
            step();
        end
        wake_valid = 2'b00;
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            exp_v = exp_q.pop_front();
            n_checks++; if (out_valid !== 1'b1 || out_instr !== exp_v)
                $display("FAIL full_order%0d got %b/%h exp 1/%h", n, out_valid, out_instr, exp_v); else n_pass++;
            step();
        end
        out_ready = 1'b0;
        n_checks++; if (count !== 3'd0 || out_valid !== 1'b0)
            $display("FAIL full_empty got %0d/%b exp 0/0", count, out_valid); else n_pass++;
    endtask

    task automatic test_same_edge_wake();
        logic [IW-1:0] c;
        c = mk(4'b1011, 6'd1, 6'd1, 6'd9, 6'd1, 4'hC);
        exp_q.push_back(ready_of(c));
        wake_valid = 2'b01;
        wake_tag = {6'd0, 6'd9};
        enq(c);
        wake_valid = 2'b00;
        exp_v = exp_q.pop_front();
        n_checks++; if (out_valid !== 1'b1 || out_instr !== exp_v)
            $display("FAIL same_edge got %b/%h exp 1/%h", out_valid, out_instr, exp_v); else n_pass++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [IW-1:0] d, e, f, g;
        d = mk(4'b1111, 6'd3, 6'd3, 6'd3, 6'd3, 4'hD);
        e = mk(4'b0000, 6'd40, 6'd41, 6'd42, 6'd43, 4'hE);
        f = mk(4'b0000, 6'd44, 6'd45, 6'd46, 6'd47, 4'h6);
        g = mk(4'b0000, 6'd50, 6'd51, 6'd52, 6'd53, 4'h7);
        exp_q.push_back(d);
        exp_q.push_back(ready_of(e));
        exp_q.push_back(ready_of(f));
        exp_q.push_back(ready_of(g));
        enq(d);
        enq(e);
        enq(f);
        exp_v = exp_q.pop_front();
        n_checks++; if (out_valid !== 1'b1 || out_instr !== exp_v)
            $display("FAIL b2b_head got %b/%h exp 1/%h", out_valid, out_instr, exp_v); else n_pass++;
        out_ready = 1'b1;
        enq(g);
        out_ready = 1'b0;
        n_checks++; if (count !== 3'd3) $display("FAIL b2b_count got %0d exp 3", count); else n_pass++;
        for (int t = 40; t < 56; t += 2) begin
            wake_valid = 2'b11;
            wake_tag = {6'(t + 1), 6'(t)};
            step();
        end
        wake_valid = 2'b00;
        out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            exp_v = exp_q.pop_front();
            n_checks++; if (out_valid !== 1'b1 || out_instr !== exp_v)
                $display("FAIL b2b_order%0d got %b/%h exp 1/%h", n, out_valid, out_instr, exp_v); else n_pass++;
            step();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        enq(mk(4'b1111, 6'd1, 6'd1, 6'd1, 6'd1, 4'h8));
        enq(mk(4'b0000, 6'd30, 6'd30, 6'd30, 6'd30, 4'h9));
        enq(mk(4'b0000, 6'd31, 6'd31, 6'd31, 6'd31, 4'hB));
        n_checks++; if (count !== 3'd3 || out_valid !== 1'b1)
            $display("FAIL flush_pre got %0d/%b exp 3/1", count, out_valid); else n_pass++;
        flush = 1'b1;
        out_ready = 1'b1;
        enq(mk(4'b1111, 6'd2, 6'd2, 6'd2, 6'd2, 4'h4));
        flush = 1'b0;
        n_checks++; if (count !== 3'd0 || out_valid !== 1'b0)
            $display("FAIL flush_post got %0d/%b exp 0/0", count, out_valid); else n_pass++;
        step();
        out_ready = 1'b0;
        n_checks++; if (count !== 3'd0 || out_valid !== 1'b0)
            $display("FAIL flush_dropped got %0d/%b exp 0/0", count, out_valid); else n_pass++;
    endtask

    task automatic test_async_reset();
        enq(mk(4'b1111, 6'd1, 6'd1, 6'd1, 6'd1, 4'h3));
        enq(mk(4'b0000, 6'd20, 6'd20, 6'd20, 6'd20, 4'h5));
        n_checks++; if (out_valid !== 1'b1 || count !== 3'd2)
            $display("FAIL areset_pre got %b/%0d exp 1/2", out_valid, count); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || out_instr !== '0)
            $display("FAIL areset_out got %b/%h exp 0/0", out_valid, out_instr); else n_pass++;
        n_checks++; if (count !== 3'd0 || in_ready !== 1'b1)
            $display("FAIL areset_cnt got %0d/%b exp 0/1", count, in_ready); else n_pass++;
        step();
        rst_n = 1'b1;
        step();
        n_checks++; if (count !== 3'd0 || out_valid !== 1'b0)
            $display("FAIL areset_after got %0d/%b exp 0/0", count, out_valid); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_young_first();
        test_full();
        test_same_edge_wake();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
